// File: rtl/mem_wb.sv
// mem_wb: elastic MEM -> write-back pipeline register with a 2-entry skid
// buffer (main + skid), a forwarding lookup for ID, and a retired-write counter.
//
// Ports
//   clk, rst           : clock (rising edge), async active-low reset
//   mem_valid/ready    : MEM-side handshake; mem_ready depends only on flops + flush
//   mem_wd/wreg/wdata  : incoming result (dest reg, write enable, data)
//   flush              : synchronous discard of both buffered entries
//   wb_valid/ready     : write-back handshake
//   wb_wd/wreg/wdata   : presented entry (wd/wdata stale when !wb_valid)
//   fwd_raddr          : ID-stage lookup address
//   fwd_hit/fwd_data   : newest matching buffered write (0 when no match)
//   retire_cnt         : completed transfers with wb_wreg=1, wraps mod 2^CNT_W
module mem_wb #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [4:0]       mem_wd,
   input  logic             mem_wreg,
   input  logic [31:0]      mem_wdata,
   input  logic             flush,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [4:0]       wb_wd,
   output logic             wb_wreg,
   output logic [31:0]      wb_wdata,
   input  logic [4:0]       fwd_raddr,
   output logic             fwd_hit,
   output logic [31:0]      fwd_data,
   output logic [CNT_W-1:0] retire_cnt
);

   typedef struct packed {
      logic        v;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
   } ent_t;

   ent_t main_q, skid_q, in_ent;
   logic accept, drain, hit_main, hit_skid;

   assign in_ent    = '{v: 1'b1, wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata};

   // Ready comes from the skid flop only, so wb_ready never reaches mem_ready.
   assign mem_ready = !skid_q.v && !flush;
   assign accept    = mem_valid && mem_ready;
   assign wb_valid  = main_q.v && !flush;
   assign drain     = wb_valid && wb_ready;

   assign wb_wd     = main_q.wd;
   assign wb_wdata  = main_q.wdata;
   assign wb_wreg   = main_q.wreg && wb_valid;

   // r0 is hardwired zero, never forward it. Skid is younger, so it wins.
   assign hit_skid  = skid_q.v && skid_q.wreg && (skid_q.wd == fwd_raddr) && (fwd_raddr != 5'd0);
   assign hit_main  = main_q.v && main_q.wreg && (main_q.wd == fwd_raddr) && (fwd_raddr != 5'd0);
   assign fwd_hit   = (hit_skid || hit_main) && !flush;
   assign fwd_data  = hit_skid ? skid_q.wdata :
                      hit_main ? main_q.wdata : 32'd0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         retire_cnt <= '0;
      end else if (flush) begin
         main_q.v <= 1'b0;
         skid_q.v <= 1'b0;
      end else begin
         if (drain && wb_wreg)
            retire_cnt <= retire_cnt + CNT_W'(1);
         if (drain) begin
            if (skid_q.v) begin
               // mem_ready was low, so no accept can coincide with this move.
               main_q   <= skid_q;
               skid_q.v <= 1'b0;
            end else if (accept) begin
               main_q <= in_ent;
            end else begin
               main_q.v <= 1'b0;
            end
         end else if (accept) begin
            if (main_q.v) skid_q <= in_ent;
            else          main_q <= in_ent;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb.sv
module tb_mem_wb;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             mem_valid = 1'b0, mem_ready;
   logic [4:0]       mem_wd = '0;
   logic             mem_wreg = 1'b0;
   logic [31:0]      mem_wdata = '0;
   logic             flush = 1'b0;
   logic             wb_valid, wb_ready = 1'b0;
   logic [4:0]       wb_wd;
   logic             wb_wreg;
   logic [31:0]      wb_wdata;
   logic [4:0]       fwd_raddr = '0;
   logic             fwd_hit;
   logic [31:0]      fwd_data;
   logic [CNT_W-1:0] retire_cnt;

   int checks = 0;
   int failures = 0;

   mem_wb #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .flush(flush),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] wd, input logic wreg, input logic [31:0] d);
      mem_valid = v; mem_wd = wd; mem_wreg = wreg; mem_wdata = d;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
      checks++; if (wb_wreg !== 1'b0) begin failures++; $display("FAIL reset_wb_wreg got=%b exp=0", wb_wreg); end
      checks++; if (retire_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", retire_cnt); end
      checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL reset_mem_ready got=%b exp=1", mem_ready); end
      @(negedge clk); rst = 1'b1;
      step();
   endtask

   task automatic test_streaming();
      wb_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 5'(i), 1'b1, 32'h100 + 32'(i));
         checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL stream_ready%0d got=%b exp=1", i, mem_ready); end
         step();
         checks++;
         if (wb_valid !== 1'b1 || wb_wd !== 5'(i) || wb_wdata !== 32'h100 + 32'(i) || wb_wreg !== 1'b1) begin
            failures++;
            $display("FAIL stream_out%0d got v=%b wd=%0d d=%h exp v=1 wd=%0d d=%h", i, wb_valid, wb_wd, wb_wdata, i, 32'h100 + 32'(i));
         end
      end
      drive(1'b0, 5'd0, 1'b0, 32'd0);
      step();
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL stream_empty got=%b exp=0", wb_valid); end
      checks++; if (retire_cnt !== 4'd8) begin failures++; $display("FAIL stream_cnt got=%0d exp=8", retire_cnt); end
   endtask

   task automatic test_stall();
      wb_ready = 1'b0;
      drive(1'b1, 5'd3, 1'b1, 32'hA);
      step();
      drive(1'b1, 5'd4, 1'b1, 32'hB);
      checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_b got=%b exp=1", mem_ready); end
      step();
      drive(1'b1, 5'd5, 1'b1, 32'hC);
      checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_full got=%b exp=0", mem_ready); end
      step();
      checks++; if (wb_valid !== 1'b1 || wb_wd !== 5'd3 || wb_wdata !== 32'hA) begin failures++; $display("FAIL stall_hold got v=%b wd=%0d exp v=1 wd=3", wb_valid, wb_wd); end
      checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_hold got=%b exp=0", mem_ready); end
      wb_ready = 1'b1;
      step();
      checks++; if (wb_wd !== 5'd4 || wb_wdata !== 32'hB) begin failures++; $display("FAIL stall_b got wd=%0d exp=4", wb_wd); end
      checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL stall_recover got=%b exp=1", mem_ready); end
      step();
      checks++; if (wb_valid !== 1'b1 || wb_wd !== 5'd5 || wb_wdata !== 32'hC) begin failures++; $display("FAIL stall_c got v=%b wd=%0d exp v=1 wd=5", wb_valid, wb_wd); end
      drive(1'b0, 5'd0, 1'b0, 32'd0);
      step();
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%b exp=0", wb_valid); end
      checks++; if (retire_cnt !== 4'd11) begin failures++; $display("FAIL stall_cnt got=%0d exp=11", retire_cnt); end
   endtask

   task automatic test_forwarding();
      wb_ready = 1'b0;
      drive(1'b1, 5'd7, 1'b1, 32'h11); step();
      drive(1'b1, 5'd7, 1'b1, 32'h22); step();
      drive(1'b0, 5'd0, 1'b0, 32'd0);
      fwd_raddr = 5'd7; #1;
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin failures++; $display("FAIL fwd_prio got hit=%b d=%h exp hit=1 d=22", fwd_hit, fwd_data); end
      fwd_raddr = 5'd5; #1;
      checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin failures++; $display("FAIL fwd_miss got hit=%b d=%h exp hit=0 d=0", fwd_hit, fwd_data); end
      fwd_raddr = 5'd7; flush = 1'b1; #1;
      checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_flush got=%b exp=0", fwd_hit); end
      step(); flush = 1'b0;
      drive(1'b1, 5'd0, 1'b1, 32'h33); step();
      drive(1'b0, 5'd0, 1'b0, 32'd0);
      fwd_raddr = 5'd0; #1;
      checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin failures++; $display("FAIL fwd_r0 got hit=%b d=%h exp hit=0 d=0", fwd_hit, fwd_data); end
      flush = 1'b1; step(); flush = 1'b0;
      drive(1'b1, 5'd7, 1'b0, 32'h44); step();
      drive(1'b0, 5'd0, 1'b0, 32'd0);
      fwd_raddr = 5'd7; #1;
      checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_nowreg got=%b exp=0", fwd_hit); end
      checks++; if (wb_valid !== 1'b1 || wb_wreg !== 1'b0) begin failures++; $display("FAIL wb_wreg_store got v=%b wreg=%b exp v=1 wreg=0", wb_valid, wb_wreg); end
      flush = 1'b1; step(); flush = 1'b0;
      drive(1'b1, 5'd9, 1'b1, 32'h55); step();
      drive(1'b0, 5'd0, 1'b0, 32'd0);
      fwd_raddr = 5'd9; #1;
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h55) begin failures++; $display("FAIL fwd_main got hit=%b d=%h exp hit=1 d=55", fwd_hit, fwd_data); end
      flush = 1'b1; step(); flush = 1'b0;
      checks++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0) begin failures++; $display("FAIL fwd_cleanup got v=%b wreg=%b exp 0", wb_valid, wb_wreg); end
   endtask

   task automatic test_flush();
      wb_ready = 1'b0;
      drive(1'b1, 5'd10, 1'b1, 32'hAA); step();
      drive(1'b1, 5'd11, 1'b1, 32'hBB); step();
      flush = 1'b1; wb_ready = 1'b1;
      drive(1'b1, 5'd12, 1'b1, 32'hCC); #1;
      checks++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0) begin failures++; $display("FAIL flush_wb_valid got v=%b wreg=%b exp 0", wb_valid, wb_wreg); end
      checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL flush_mem_ready got=%b exp=0", mem_ready); end
      step();
      flush = 1'b0; drive(1'b0, 5'd0, 1'b0, 32'd0); #1;
      checks++; if (wb_valid !== 1'b0 || mem_ready !== 1'b1) begin failures++; $display("FAIL flush_empty got v=%b rdy=%b exp v=0 rdy=1", wb_valid, mem_ready); end
      checks++; if (retire_cnt !== 4'd11) begin failures++; $display("FAIL flush_cnt got=%0d exp=11", retire_cnt); end
      step();
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", wb_valid); end
   endtask

   task automatic test_reset_mid();
      wb_ready = 1'b0;
      drive(1'b1, 5'd20, 1'b1, 32'hDEAD); step();
      drive(1'b1, 5'd21, 1'b1, 32'hBEEF); step();
      fwd_raddr = 5'd21;
      #2 rst = 1'b0;
      #1;
      checks++; if (wb_valid !== 1'b0 || wb_wreg !== 1'b0 || wb_wd !== 5'd0 || wb_wdata !== 32'd0) begin
         failures++; $display("FAIL rstmid_wb got v=%b wreg=%b wd=%0d d=%h exp all 0", wb_valid, wb_wreg, wb_wd, wb_wdata);
      end
      checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin failures++; $display("FAIL rstmid_fwd got hit=%b d=%h exp 0", fwd_hit, fwd_data); end
      checks++; if (retire_cnt !== 4'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", retire_cnt); end
      drive(1'b0, 5'd0, 1'b0, 32'd0);
      @(negedge clk); rst = 1'b1;
      step();
      checks++; if (mem_ready !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL rstmid_release got rdy=%b v=%b exp rdy=1 v=0", mem_ready, wb_valid); end
   endtask

   task automatic test_counter_wrap();
      wb_ready = 1'b1;
      // 22 entries; every 4th (5 total) is a non-writing entry, leaving 17 writes.
      for (int i = 0; i < 22; i++) begin
         drive(1'b1, 5'(i + 1), (i % 4) != 0 || i >= 20, 32'(i));
         step();
      end
      drive(1'b0, 5'd0, 1'b0, 32'd0);
      step();
      checks++; if (retire_cnt !== 4'd1) begin failures++; $display("FAIL cnt_wrap got=%0d exp=1", retire_cnt); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_stall();
      test_forwarding();
      test_flush();
      test_reset_mid();
      test_counter_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_wb.md
# mem_wb

Pipeline register between the MEM stage and the write-back/regfile port, upgraded from a plain flop stage to a valid/ready elastic stage with a 2-entry skid buffer. It accepts one MEM result per cycle and presents it to write-back one cycle later. It absorbs one cycle of write-back back-pressure without a combinational ready path to MEM. It also exposes a forwarding lookup over its buffered entries for the ID stage and a retired-write counter.

## Interface
- `CNT_W`, default 32: width of the retired-write counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: the MEM stage is presenting a result this cycle.
- `mem_ready` out 1: this block can accept a result this cycle.
- `mem_wd` in 5: destination register address.
- `mem_wreg` in 1: write enable for the result.
- `mem_wdata` in 32: result data.
- `flush` in 1: synchronous discard of every buffered entry.
- `wb_valid` out 1: an entry is presented to write-back.
- `wb_ready` in 1: write-back consumes the presented entry this cycle.
- `wb_wd` out 5: destination register address presented to write-back.
- `wb_wreg` out 1: write enable presented to write-back.
- `wb_wdata` out 32: data presented to write-back.
- `fwd_raddr` in 5: ID-stage read address to look up.
- `fwd_hit` out 1: a buffered entry matches `fwd_raddr`.
- `fwd_data` out 32: data of the matching entry.
- `retire_cnt` out CNT_W: count of completed write-back transfers with `wb_wreg`=1.

## Operation
- Storage consists of two entries:
  - `main` drives the `wb_*` outputs.
  - `skid` holds the newer entry when `main` is stalled.
  - Each entry holds `{valid, wd, wreg, wdata}`.
- Handshakes:
  - `mem_ready` = !skid.valid & !flush. `skid.valid` is a flop, so there is no combinational path from `wb_ready` to `mem_ready`.
  - Accept = mem_valid & mem_ready.
  - `wb_valid` = main.valid & !flush.
  - Drain = wb_valid & wb_ready.
- Next state when `flush`=0:
  - Drain and skid valid: skid moves to main. An accept is impossible in this case.
  - Drain and skid empty: an accept loads main; otherwise main.valid clears.
  - No drain, main valid, accept: the accept loads skid.
  - No drain, main empty, accept: the accept loads main.
  - Otherwise everything holds.
- Occupancy never exceeds 2. Order is strictly FIFO: skid is always younger than main.
- Entries with `mem_wreg`=0 (stores, branches) are real entries and flow normally. They never hit on forwarding and never increment the counter.
- `wb_wreg` = main.wreg & wb_valid, so `wb_wreg` is never 1 when there is no valid entry. `wb_wd` and `wb_wdata` hold stale values when not valid.
- Forwarding (combinational):
  - An entry is a candidate if valid & wreg & wd == fwd_raddr & fwd_raddr != 0.
  - skid has priority over main, because it is newer.
  - `fwd_hit`=0 and `fwd_data`=0 when there is no candidate.
  - `fwd_hit` is forced 0 while `flush`=1.
- `retire_cnt` increments by 1 on drain & wb_wreg. It wraps modulo 2^CNT_W and is not cleared by `flush`.
- `flush`=1:
  - Both valids clear at the next edge.
  - Any `mem_*` input that cycle is not accepted.
  - No drain occurs, so the counter does not change.
  - Flush takes priority over all other events in the same cycle.

## Timing
- Reset (async assert, any time including mid-transfer):
  - Both valids are 0.
  - All stored wd/wdata are 0, and `retire_cnt`=0.
  - Outputs: `wb_valid`=0, `wb_wreg`=0, `wb_wd`=0, `wb_wdata`=0, `fwd_hit`=0, `fwd_data`=0.
  - `mem_ready`=1 once flops are reset, since skid is empty.
- Release of `rst` is synchronous to `clk`. The first accept is possible on the first edge after deassertion.
- Latency: a result accepted at edge N is visible on `wb_*` after edge N, i.e. one cycle.
- Throughput: 1 entry/cycle when `wb_ready`=1 continuously.
- Back-pressure: with `wb_ready` low for k≥1 cycles, at most one extra entry is accepted, and `mem_ready` falls 1 cycle after skid fills.
- Recovery: when `wb_ready` returns high with both entries full, `mem_ready` rises one cycle after the first drain.
- All outputs except `mem_ready`, `wb_valid`, `wb_wreg`, `fwd_hit` and `fwd_data` are direct flop outputs. Those five add only AND/compare logic on local flops plus `flush`/`fwd_raddr`.

## Test plan
- **Reset mid-stream:** assert `rst`=0 while both entries are full. Required: all outputs are 0 immediately (asynchronously), `retire_cnt`=0, and `mem_ready`=1 after release.
- **Streaming:** `wb_ready`=1; send wd=1..8 with wdata=0x100+i, wreg=1, on consecutive cycles. Required: each appears on `wb_*` one cycle later, in order, with no bubbles, and `retire_cnt`=8.
- **Stall/skid:** hold `wb_ready`=0 for 3 cycles while `mem_valid`=1 with A (wd=3), B (wd=4), C (wd=5).
  - Required: A is held on `wb_*`, B sits in skid, and `mem_ready`=0 so C is held upstream.
  - After `wb_ready`=1: A, B, C drain in order with no loss or duplication.
- **Forwarding priority:** main={wd=7, data=0x11}, skid={wd=7, data=0x22}.
  - `fwd_raddr`=7 → `fwd_hit`=1, `fwd_data`=0x22.
  - `fwd_raddr`=0 with wd=0 buffered → `fwd_hit`=0.
  - A wreg=0 entry at wd=7 alone → `fwd_hit`=0.
- **Flush with simultaneous accept and `wb_ready`:** both entries full, `flush`=1, `mem_valid`=1, `wb_ready`=1. Required: `wb_valid`=0 that cycle, both entries are empty next cycle, the counter is unchanged, and the incoming entry is dropped.
- **Counter wrap:** with `CNT_W`=4, retire 17 writes interleaved with 5 wreg=0 entries. Required: `retire_cnt`=1.
